// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port_arbiter                                             |
// | Purpose  : Shares one SRAM controller between the D and I request ports, |
// |            holding each grant for a whole transaction.                   |
// | Options  : ARB_ROUND_ROBIN_EN selects round-robin ties (default: D wins) |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_rd_en,
    input  logic               d_wr_en,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [WDATA_W-1:0] d_wdata,
    output logic [RDATA_W-1:0] d_rdata,
    output logic               d_ready,
    input  logic               i_rd_en,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_address,
    input  logic [WDATA_W-1:0] i_wdata,
    output logic [RDATA_W-1:0] i_rdata,
    output logic               i_ready,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [ADDR_W-1:0]  sram_address,
    output logic [WDATA_W-1:0] sram_wdata,
    input  logic [RDATA_W-1:0] sram_rdata,
    input  logic               sram_ready,
    output logic [1:0]         grant,
    output logic               busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_D = 2'd1;
    localparam logic [1:0] c_GNT_I = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_d_req;
    logic               w_i_req;
    logic               w_d_done;
    logic               w_i_done;
    logic               w_tie_i;
    logic [RDATA_W-1:0] r_d_rdata;
    logic [RDATA_W-1:0] r_i_rdata;

    assign w_d_req  = d_rd_en | d_wr_en;
    assign w_i_req  = i_rd_en | i_wr_en;
    // Reset suppresses completion so an abandoned access never signals ready
    assign w_d_done = (r_state == c_GNT_D) & sram_ready & ~rst;
    assign w_i_done = (r_state == c_GNT_I) & sram_ready & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_i <= 1'b1;
        end else if (w_d_done) begin
            r_last_i <= 1'b0;
        end else if (w_i_done) begin
            r_last_i <= 1'b1;
        end
    end

    assign w_tie_i = ~r_last_i;
`else
    assign w_tie_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_d_req && w_i_req) begin
                    w_state_nxt = w_tie_i ? c_GNT_I : c_GNT_D;
                end else if (w_d_req) begin
                    w_state_nxt = c_GNT_D;
                end else if (w_i_req) begin
                    w_state_nxt = c_GNT_I;
                end
            end
            c_GNT_D: if (sram_ready) w_state_nxt = c_IDLE;
            c_GNT_I: if (sram_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Write wins over read inside a port
    always_comb begin
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        grant        = 2'b00;
        case (r_state)
            c_GNT_D: begin
                sram_wr_en   = d_wr_en;
                sram_rd_en   = d_rd_en & ~d_wr_en;
                sram_address = d_address;
                sram_wdata   = d_wdata;
                grant        = 2'b01;
            end
            c_GNT_I: begin
                sram_wr_en   = i_wr_en;
                sram_rd_en   = i_rd_en & ~i_wr_en;
                sram_address = i_address;
                sram_wdata   = i_wdata;
                grant        = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_rdata <= '0;
            r_i_rdata <= '0;
        end else begin
            if (w_d_done) r_d_rdata <= sram_rdata;
            if (w_i_done) r_i_rdata <= sram_rdata;
        end
    end

    assign d_ready = w_d_done;
    assign i_ready = w_i_done;
    assign d_rdata = w_d_done ? sram_rdata : r_d_rdata;
    assign i_rdata = w_i_done ? sram_rdata : r_i_rdata;
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_port_arbiter                                          |
// | Purpose  : Randomised scoreboard bench for sram_port_arbiter with an     |
// |            SRAM controller model. Honours ARB_ROUND_ROBIN_EN.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_rd_en = 1'b0, d_wr_en = 1'b0;
    logic [31:0] d_address = '0, d_wdata = '0;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        i_rd_en = 1'b0, i_wr_en = 1'b0;
    logic [31:0] i_address = '0, i_wdata = '0;
    logic [63:0] i_rdata;
    logic        i_ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [1:0]  grant;
    logic        busy;

    logic        mdl_ready = 1'b0;
    logic        spur_ready = 1'b0;
    logic [63:0] mdl_rdata = '0;
    assign sram_ready = mdl_ready | spur_ready;
    assign sram_rdata = mdl_rdata;

    int checks = 0;
    int errors = 0;
    int fixed_lat = 0;
    bit log_en = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    xact_t      d_q[$];
    xact_t      i_q[$];
    logic [1:0] order_q[$];
    logic [1:0] exp_order[$];

`ifdef ARB_ROUND_ROBIN_EN
    localparam int N_D_TIE = 2;
    localparam int N_I_TIE = 2;
`else
    localparam int N_D_TIE = 4;
    localparam int N_I_TIE = 1;
`endif

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data the SRAM model returns for an address; 0x40 maps to 1122_3344_5566_7788
    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return 64'h1122_3344_5566_7788 ^ {32'h0, a ^ 32'h40};
    endfunction

    function automatic logic [1:0] pick(input logic dq, input logic iq, input logic lasti);
        logic [1:0] g;
        g = {iq, dq};
        if (dq && iq) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = lasti ? 2'b01 : 2'b10;
`else
            g = 2'b01;
`endif
        end
        return g;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit p, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        xact_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
        if (!p) begin
            d_q.push_back(t);
            d_rd_en = rd; d_wr_en = wr; d_address = a; d_wdata = wd;
        end else begin
            i_q.push_back(t);
            i_rd_en = rd; i_wr_en = wr; i_address = a; i_wdata = wd;
        end
    endtask

    task automatic xact(input bit p, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 1'b0;
        issue(p, rd, wr, a, wd);
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = p ? i_ready : d_ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: port %0d addr %h got no ready, required within 300 cycles", p, a);
        end
        @(posedge clk); #1;
    endtask

    task automatic drop(input bit p);
        if (!p) begin
            d_rd_en = 1'b0; d_wr_en = 1'b0;
        end else begin
            i_rd_en = 1'b0; i_wr_en = 1'b0;
        end
    endtask

    // SRAM controller model: starts on an enable, answers after a latency,
    // and needs the enables low for a cycle before accepting the next access.
    bit          s_active = 1'b0;
    bit          s_armed  = 1'b1;
    bit          s_nxt    = 1'b0;
    int          s_cnt    = 0;
    logic [31:0] s_addr   = '0;

    initial begin
        forever begin
            @(negedge clk);
            s_nxt = 1'b0;
            if (rst) begin
                s_active = 1'b0;
                s_armed  = 1'b1;
            end else if (mdl_ready) begin
                s_active = 1'b0;
            end else if (s_active) begin
                if (s_cnt <= 1) s_nxt = 1'b1;
                else s_cnt--;
            end else if (s_armed && (sram_rd_en || sram_wr_en)) begin
                s_active = 1'b1;
                s_armed  = 1'b0;
                s_addr   = sram_address;
                s_cnt    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
            end
            if (!(sram_rd_en || sram_wr_en)) s_armed = 1'b1;
            @(posedge clk); #1;
            mdl_ready = s_nxt;
            mdl_rdata = s_nxt ? mem_data(s_addr) : {$urandom, $urandom};
        end
    end

    // Monitor: reference arbitration model plus per-port scoreboards
    logic [1:0]  pg = 2'b00, exp_g = 2'b00;
    logic        pd = 1'b0, pi = 1'b0, prdy = 1'b0, prst = 1'b1, m_last_i = 1'b1;
    logic        edr, eir;
    logic [63:0] m_d = '0, m_i = '0;
    xact_t       mt;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                d_q.delete(); i_q.delete();
                m_last_i = 1'b1; m_d = '0; m_i = '0;
                pg = 2'b00; prst = 1'b1;
            end else begin
                if (prst) exp_g = 2'b00;
                else if (pg == 2'b00) exp_g = pick(pd, pi, m_last_i);
                else exp_g = prdy ? 2'b00 : pg;

                chk("grant", {62'h0, grant}, {62'h0, exp_g});
                chk("busy", {63'h0, busy}, {63'h0, exp_g != 2'b00});
                if (exp_g == 2'b00) begin
                    chk("idle_en", {62'h0, sram_rd_en, sram_wr_en}, 64'h0);
                    chk("idle_addr_wdata", {sram_address, sram_wdata}, 64'h0);
                end
                if (exp_g == 2'b01)
                    assert (d_rd_en || d_wr_en)
                    else begin errors++; $error("FAIL withdraw: D request dropped while granted"); end
                if (exp_g == 2'b10)
                    assert (i_rd_en || i_wr_en)
                    else begin errors++; $error("FAIL withdraw: I request dropped while granted"); end

                if (exp_g != 2'b00 && pg == 2'b00) begin
                    if (log_en) order_q.push_back(grant);
                    if ((exp_g[0] && d_q.size() == 0) || (exp_g[1] && i_q.size() == 0)) begin
                        checks++; errors++;
                        $display("FAIL grant_start: grant %b with no pending transaction", exp_g);
                    end else begin
                        mt = exp_g[0] ? d_q[0] : i_q[0];
                        chk("sram_address", {32'h0, sram_address}, {32'h0, mt.addr});
                        chk("sram_wr_en", {63'h0, sram_wr_en}, {63'h0, mt.wr});
                        chk("sram_rd_en", {63'h0, sram_rd_en}, {63'h0, mt.rd & ~mt.wr});
                        if (mt.wr) chk("sram_wdata", {32'h0, sram_wdata}, {32'h0, mt.wdata});
                    end
                end

                edr = exp_g[0] & sram_ready;
                eir = exp_g[1] & sram_ready;
                chk("d_ready", {63'h0, d_ready}, {63'h0, edr});
                chk("i_ready", {63'h0, i_ready}, {63'h0, eir});
                if (edr) begin
                    if (d_q.size() == 0) begin
                        checks++; errors++; $display("FAIL d_pop: ready with empty D queue");
                    end else begin
                        mt = d_q.pop_front(); m_d = mem_data(mt.addr);
                    end
                end
                if (eir) begin
                    if (i_q.size() == 0) begin
                        checks++; errors++; $display("FAIL i_pop: ready with empty I queue");
                    end else begin
                        mt = i_q.pop_front(); m_i = mem_data(mt.addr);
                    end
                end
                chk("d_rdata", d_rdata, m_d);
                chk("i_rdata", i_rdata, m_i);
                if (exp_g != 2'b00 && sram_ready) m_last_i = exp_g[1];

                pg = exp_g; prst = 1'b0;
            end
            pd = d_rd_en | d_wr_en;
            pi = i_rd_en | i_wr_en;
            prdy = sram_ready;
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", {62'h0, grant}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_sram_rd_en", {63'h0, sram_rd_en}, 64'h0);
        chk("rst_sram_wr_en", {63'h0, sram_wr_en}, 64'h0);
        chk("rst_sram_address", {32'h0, sram_address}, 64'h0);
        chk("rst_sram_wdata", {32'h0, sram_wdata}, 64'h0);
        chk("rst_d_ready", {63'h0, d_ready}, 64'h0);
        chk("rst_i_ready", {63'h0, i_ready}, 64'h0);
        chk("rst_d_rdata", d_rdata, 64'h0);
        chk("rst_i_rdata", i_rdata, 64'h0);

        // Tie: both ports hold read requests back-to-back
        @(posedge clk); #1;
        log_en = 1'b1;
        fork
            begin
                for (int k = 0; k < N_D_TIE; k++) xact(1'b0, 1'b1, 1'b0, 32'h1000 + 32'(k * 4), 32'h0);
                drop(1'b0);
            end
            begin
                for (int k = 0; k < N_I_TIE; k++) xact(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(k * 4), 32'h0);
                drop(1'b1);
            end
        join
        log_en = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
        chk("tie_order_len", 64'(order_q.size()), 64'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && k < order_q.size(); k++)
            chk($sformatf("tie_order[%0d]", k), {62'h0, order_q[k]}, {62'h0, exp_order[k]});

        // Single D read with 5-cycle SRAM latency
        fixed_lat = 5;
        fork
            xact(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
            begin
                @(negedge clk);
                chk("rd_en_in_idle", {63'h0, sram_rd_en}, 64'h0);
                @(negedge clk);
                chk("rd_en_at_n_plus_1", {63'h0, sram_rd_en}, 64'h1);
            end
        join
        drop(1'b0);
        @(negedge clk);
        chk("d_rdata_hold", d_rdata, 64'h1122_3344_5566_7788);

        // Write wins inside the I port
        @(posedge clk); #1;
        fixed_lat = 3;
        fork
            xact(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
            begin
                repeat (2) @(negedge clk);
                chk("ww_wr_en", {63'h0, sram_wr_en}, 64'h1);
                chk("ww_rd_en", {63'h0, sram_rd_en}, 64'h0);
                chk("ww_wdata", {32'h0, sram_wdata}, 64'hDEAD_BEEF);
            end
        join
        drop(1'b1);

        // Spurious completion while idle
        spur_ready = 1'b1;
        @(negedge clk);
        chk("spur_d_ready", {63'h0, d_ready}, 64'h0);
        chk("spur_i_ready", {63'h0, i_ready}, 64'h0);
        chk("spur_grant", {62'h0, grant}, 64'h0);
        @(posedge clk); #1;
        spur_ready = 1'b0;

        // Reset in the middle of a D write, then a clean D read
        fixed_lat = 8;
        issue(1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFE_F00D);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drop(1'b0);
        @(negedge clk);
        chk("mid_rst_grant", {62'h0, grant}, 64'h0);
        chk("mid_rst_wr_en", {63'h0, sram_wr_en}, 64'h0);
        chk("mid_rst_d_ready", {63'h0, d_ready}, 64'h0);
        chk("mid_rst_busy", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        fixed_lat = 0;
        xact(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
        drop(1'b0);

        // Randomised traffic on both ports
        fork
            for (int n = 0; n < 30; n++) begin
                int g;
                int mode;
                g = int'($urandom_range(0, 3));
                repeat (g) begin @(posedge clk); #1; end
                mode = int'($urandom_range(0, 2));
                xact(1'b0, mode != 1, mode != 0, $urandom & 32'hFFFF_FFFC, $urandom);
                drop(1'b0);
            end
            for (int n = 0; n < 30; n++) begin
                int g;
                int mode;
                g = int'($urandom_range(0, 3));
                repeat (g) begin @(posedge clk); #1; end
                mode = int'($urandom_range(0, 2));
                xact(1'b1, mode != 1, mode != 0, $urandom & 32'hFFFF_FFFC, $urandom);
                drop(1'b1);
            end
        join

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
